// File: rtl/snn_noc_pkg.sv
// Shared definitions for the PE-side NoC endpoint: packet layout, type codes,
// field widths and the outgoing packet builder.
package snn_noc_pkg;

  typedef enum logic [1:0] {
    TYPE_INPUT  = 2'b00,
    TYPE_KERNEL = 2'b01,
    TYPE_OUTPUT = 2'b11
  } pkt_type_e;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  localparam int SRC_MSB   = 63;
  localparam int DST_MSB   = 59;
  localparam int TYPE_MSB  = 55;
  localparam int PAYLOAD_W = TYPE_MSB - 1;  // 54 payload bits below the type field
  localparam int FILTER_W  = 40;
  localparam int IFMAP_W   = 25;
  localparam int COORD_W   = 5;

  // Payload code for an end-of-timestep marker.
  localparam logic [9:0] DONE = 10'h1FF;

  typedef struct packed {
    logic [SRC_MSB:DST_MSB+1]   src;
    logic [DST_MSB:TYPE_MSB+1]  dst;
    logic [TYPE_MSB:PAYLOAD_W]  ptype;
    logic [PAYLOAD_W-1:0]       payload;
  } noc_pkt_t;

  // Outgoing packets always carry a 10-bit code in the low payload bits.
  function automatic noc_pkt_t build_out_pkt(input logic [3:0] src,
                                             input logic [3:0] dst,
                                             input logic [9:0] code);
    noc_pkt_t pkt;
    pkt.src     = src;
    pkt.dst     = dst;
    pkt.ptype   = TYPE_OUTPUT;
    pkt.payload = PAYLOAD_W'(code);
    return pkt;
  endfunction

endpackage

// File: rtl/pe_rx_fifo.sv
// Synchronous FIFO buffering ifmap rows between the NoC and the PE datapath.
// Push is ignored when full, pop is ignored when empty.
module pe_rx_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rd_data = r_mem[r_rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Row storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; emptiness comes from r_count,
    // so stale rows are never visible and the array can map to plain RAM.
    if (w_do_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/pe_noc_endpoint.sv
// PE-side NoC endpoint: Rx decodes kernel/ifmap packets into the filter
// register and the ifmap FIFO; Tx packs spikes and end-of-timestep markers
// into output packets for the memory interface.
module pe_noc_endpoint
  import snn_noc_pkg::*;
#(
  parameter logic [3:0] PE_ADDR     = 4'b0000,
  parameter logic [3:0] MEM_ADDR    = 4'b0000,
  parameter int         IFMAP_DEPTH = 4,
  parameter int         TIMESTEPS   = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [63:0]          in_data,
  output logic [FILTER_W-1:0]  filter_row,
  output logic                 filter_valid,
  output logic                 filter_load,
  output logic                 ifmap_valid,
  input  logic                 ifmap_ready,
  output logic [IFMAP_W-1:0]   ifmap_row,
  input  logic                 spike_valid,
  output logic                 spike_ready,
  input  logic [COORD_W-1:0]   spike_x,
  input  logic [COORD_W-1:0]   spike_y,
  input  logic                 spike_done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [63:0]          out_data,
  output logic [3:0]           timestep,
  output logic                 err_misroute,
  output logic                 err_type
);

  localparam logic [3:0] TS_LAST = 4'(TIMESTEPS - 1);

  // ---------------- Rx path ----------------
  noc_pkt_t              w_in_pkt;
  logic                  w_accept;
  logic                  w_dst_ok;
  logic                  w_kernel;
  logic                  w_input;
  logic                  w_misroute;
  logic                  w_bad_type;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_unused_bits;
  logic [FILTER_W-1:0]   r_filter_row;
  logic                  r_filter_valid;
  logic                  r_filter_load;
  logic                  r_err_misroute;
  logic                  r_err_type;

  assign w_in_pkt   = in_data;
  // Same ready rule for every packet type; held low while in reset.
  assign in_ready   = !reset && !w_fifo_full;
  assign w_accept   = in_valid && in_ready;
  assign w_dst_ok   = (w_in_pkt.dst == PE_ADDR);
  assign w_misroute = w_accept && !w_dst_ok;
  assign w_kernel   = w_accept && w_dst_ok && (w_in_pkt.ptype == TYPE_KERNEL);
  assign w_input    = w_accept && w_dst_ok && (w_in_pkt.ptype == TYPE_INPUT);
  assign w_bad_type = w_accept && w_dst_ok && (w_in_pkt.ptype != TYPE_KERNEL)
                      && (w_in_pkt.ptype != TYPE_INPUT);
  // Source and upper payload bits are intentionally ignored on receive.
  assign w_unused_bits = ^{w_in_pkt.src, w_in_pkt.payload[PAYLOAD_W-1:FILTER_W]};

  // Filter register update and one-cycle status pulses for accepted packets.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_filter_row   <= '0;
      r_filter_valid <= 1'b0;
      r_filter_load  <= 1'b0;
      r_err_misroute <= 1'b0;
      r_err_type     <= 1'b0;
    end else begin
      r_filter_load  <= w_kernel;
      r_err_misroute <= w_misroute;
      r_err_type     <= w_bad_type;
      if (w_kernel) begin
        r_filter_row   <= w_in_pkt.payload[FILTER_W-1:0];
        r_filter_valid <= 1'b1;
      end
    end
  end

  pe_rx_fifo #(
    .WIDTH (IFMAP_W),
    .DEPTH (IFMAP_DEPTH)
  ) u_ifmap_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_input),
    .i_wr_data (w_in_pkt.payload[IFMAP_W-1:0]),
    .i_pop     (ifmap_ready),
    .o_rd_data (ifmap_row),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  assign filter_row   = r_filter_row;
  assign filter_valid = r_filter_valid;
  assign filter_load  = r_filter_load;
  assign ifmap_valid  = !w_fifo_empty;
  assign err_misroute = r_err_misroute;
  assign err_type     = r_err_type;

  // ---------------- Tx path ----------------
  tx_state_e   r_tx_state;
  tx_state_e   w_tx_next;
  logic        w_tx_load;
  logic        w_out_fire;
  logic [9:0]  w_tx_code;
  noc_pkt_t    w_tx_pkt;
  noc_pkt_t    r_out_data;
  logic        r_out_is_done;
  logic [3:0]  r_timestep;

  assign out_valid   = (r_tx_state == TX_SEND);
  assign spike_ready = (r_tx_state == TX_IDLE) || out_ready;
  assign w_out_fire  = out_valid && out_ready;
  // Coordinates are ignored for an end-of-timestep marker.
  assign w_tx_code   = spike_done ? DONE : {spike_x, spike_y};
  assign w_tx_pkt    = build_out_pkt(PE_ADDR, MEM_ADDR, w_tx_code);

  // Tx state register.
  always_ff @(posedge clk) begin
    if (reset) r_tx_state <= TX_IDLE;
    else       r_tx_state <= w_tx_next;
  end

  // Tx next-state and packet-load decision; back-to-back load when the
  // current packet leaves in the same cycle a new request arrives.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch
    // is inferred.
    w_tx_next = r_tx_state;
    w_tx_load = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (spike_valid) begin
          w_tx_next = TX_SEND;
          w_tx_load = 1'b1;
        end
      end
      TX_SEND: begin
        if (out_ready) begin
          if (spike_valid) w_tx_load = 1'b1;
          else             w_tx_next = TX_IDLE;
        end
      end
      default: w_tx_next = TX_IDLE;
    endcase
  end

  // Outgoing packet register, held stable until the router takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_data    <= '0;
      r_out_is_done <= 1'b0;
    end else if (w_tx_load) begin
      r_out_data    <= w_tx_pkt;
      r_out_is_done <= spike_done;
    end
  end

  // Timestep advances when an end-of-timestep marker leaves the endpoint.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timestep <= '0;
    end else if (w_out_fire && r_out_is_done) begin
      r_timestep <= (r_timestep == TS_LAST) ? '0 : r_timestep + 1'b1;
    end
  end

  assign out_data = r_out_data;
  assign timestep = r_timestep;

endmodule

// File: tb/tb_pe_noc_endpoint.sv
// Self-checking bench for pe_noc_endpoint: table-driven Rx vectors, a
// scoreboard for ifmap rows and outgoing packets, and hand-written sequences
// for back-pressure, FIFO-full, timestep wrap and mid-operation reset.
module tb_pe_noc_endpoint;

  localparam logic [3:0] TB_PE  = 4'h3;
  localparam logic [3:0] TB_MEM = 4'hC;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [39:0] filter_row;
  logic        filter_valid;
  logic        filter_load;
  logic        ifmap_valid;
  logic        ifmap_ready;
  logic [24:0] ifmap_row;
  logic        spike_valid;
  logic        spike_ready;
  logic [4:0]  spike_x;
  logic [4:0]  spike_y;
  logic        spike_done;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [3:0]  timestep;
  logic        err_misroute;
  logic        err_type;

  int n_checks = 0;
  int n_errors = 0;

  logic [24:0] ifmap_q [$];
  logic [63:0] out_q   [$];
  logic [24:0] mon_row;
  logic [63:0] mon_pkt;

  typedef struct {
    logic [63:0] data;
    logic        mis;
    logic        typ;
    logic        load;
    logic [39:0] row;
    logic        fvalid;
    logic        push;
    logic [24:0] prow;
  } rx_vec_t;

  rx_vec_t rx_tab [7];

  pe_noc_endpoint #(
    .PE_ADDR     (TB_PE),
    .MEM_ADDR    (TB_MEM),
    .IFMAP_DEPTH (4),
    .TIMESTEPS   (10)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .filter_row   (filter_row),
    .filter_valid (filter_valid),
    .filter_load  (filter_load),
    .ifmap_valid  (ifmap_valid),
    .ifmap_ready  (ifmap_ready),
    .ifmap_row    (ifmap_row),
    .spike_valid  (spike_valid),
    .spike_ready  (spike_ready),
    .spike_x      (spike_x),
    .spike_y      (spike_y),
    .spike_done   (spike_done),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .timestep     (timestep),
    .err_misroute (err_misroute),
    .err_type     (err_type)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rx_pkt(input logic [3:0] dst, input logic [1:0] t,
                                         input logic [53:0] payload);
    return {4'h9, dst, t, payload};
  endfunction

  function automatic logic [63:0] tx_pkt(input logic [4:0] x, input logic [4:0] y,
                                         input logic done);
    logic [9:0] code;
    code = done ? 10'h1FF : {x, y};
    return {TB_PE, TB_MEM, 2'b11, 44'd0, code};
  endfunction

  task automatic drain(input string name);
    for (int c = 0; c < 20 && (ifmap_q.size() != 0 || out_q.size() != 0); c++) step();
    check(name, 64'(ifmap_q.size() + out_q.size()), 64'd0);
  endtask

  // Scoreboard: compare each handshake at the output ports with the queues.
  always @(negedge clk) begin
    if (!reset && ifmap_valid && ifmap_ready) begin
      if (ifmap_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL ifmap_extra: got row %h, none expected", ifmap_row);
      end else begin
        mon_row = ifmap_q.pop_front();
        check("ifmap_row", 64'(ifmap_row), 64'(mon_row));
      end
    end
    if (!reset && out_valid && out_ready) begin
      if (out_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL out_extra: got packet %h, none expected", out_data);
      end else begin
        mon_pkt = out_q.pop_front();
        check("out_pkt", out_data, mon_pkt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

  initial begin
    rx_tab[0] = '{rx_pkt(TB_PE, 2'b01, {14'h2AAA, 40'h1122334455}), 1'b0, 1'b0, 1'b1,
                  40'h1122334455, 1'b1, 1'b0, 25'h0};
    rx_tab[1] = '{rx_pkt(4'h4, 2'b01, {14'h0, 40'hDEADBEEF00}), 1'b1, 1'b0, 1'b0,
                  40'h1122334455, 1'b1, 1'b0, 25'h0};
    rx_tab[2] = '{rx_pkt(TB_PE, 2'b11, {14'h0, 40'h7777777777}), 1'b0, 1'b1, 1'b0,
                  40'h1122334455, 1'b1, 1'b0, 25'h0};
    rx_tab[3] = '{rx_pkt(TB_PE, 2'b10, {14'h0, 40'h6666666666}), 1'b0, 1'b1, 1'b0,
                  40'h1122334455, 1'b1, 1'b0, 25'h0};
    rx_tab[4] = '{rx_pkt(TB_PE, 2'b00, {29'h1FFFFFFF, 25'h0ABCDEF}), 1'b0, 1'b0, 1'b0,
                  40'h1122334455, 1'b1, 1'b1, 25'h0ABCDEF};
    rx_tab[5] = '{rx_pkt(TB_PE, 2'b01, {14'h0, 40'hA5A50F0FC3}), 1'b0, 1'b0, 1'b1,
                  40'hA5A50F0FC3, 1'b1, 1'b0, 25'h0};
    rx_tab[6] = '{rx_pkt(4'h4, 2'b00, {29'h0, 25'h1555555}), 1'b1, 1'b0, 1'b0,
                  40'hA5A50F0FC3, 1'b1, 1'b0, 25'h0};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; ifmap_ready = 1'b0;
    spike_valid = 1'b0; spike_x = '0; spike_y = '0; spike_done = 1'b0; out_ready = 1'b0;

    // Reset state
    repeat (2) step();
    check("rst_in_ready_low", 64'(in_ready), 64'd0);
    reset = 1'b0;
    #1;
    check("rst_in_ready_high", 64'(in_ready), 64'd1);
    check("rst_filter_row", 64'(filter_row), 64'd0);
    check("rst_filter_valid", 64'(filter_valid), 64'd0);
    check("rst_filter_load", 64'(filter_load), 64'd0);
    check("rst_ifmap_valid", 64'(ifmap_valid), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_timestep", 64'(timestep), 64'd0);
    check("rst_errs", 64'({err_misroute, err_type}), 64'd0);

    // Rx vector table
    ifmap_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      in_valid = 1'b1;
      in_data  = rx_tab[i].data;
      #1;
      check("rx_in_ready", 64'(in_ready), 64'd1);
      check("rx_pulses_idle", 64'({filter_load, err_misroute, err_type}), 64'd0);
      if (rx_tab[i].push) ifmap_q.push_back(rx_tab[i].prow);
      step();
      in_valid = 1'b0;
      #1;
      check("rx_err_misroute", 64'(err_misroute), 64'(rx_tab[i].mis));
      check("rx_err_type", 64'(err_type), 64'(rx_tab[i].typ));
      check("rx_filter_load", 64'(filter_load), 64'(rx_tab[i].load));
      check("rx_filter_row", 64'(filter_row), 64'(rx_tab[i].row));
      check("rx_filter_valid", 64'(filter_valid), 64'(rx_tab[i].fvalid));
    end
    drain("rx_drain");

    // FIFO fill to full, no ready-through on pop while full
    ifmap_ready = 1'b0;
    begin
      logic [24:0] rows [5];
      rows[0] = 25'h1000001; rows[1] = 25'h0AAAAAA; rows[2] = 25'h1555555;
      rows[3] = 25'h1FFFFFF; rows[4] = 25'h0123456;
      for (int k = 0; k < 4; k++) begin
        step();
        in_valid = 1'b1;
        in_data  = rx_pkt(TB_PE, 2'b00, {29'h0, rows[k]});
        #1;
        check("fill_in_ready", 64'(in_ready), 64'd1);
        ifmap_q.push_back(rows[k]);
      end
      step();
      in_data = rx_pkt(TB_PE, 2'b00, {29'h0, rows[4]});
      #1;
      check("full_in_ready", 64'(in_ready), 64'd0);
      check("full_head", 64'(ifmap_row), 64'(rows[0]));
      step();
      check("full_hold_in_ready", 64'(in_ready), 64'd0);
      ifmap_ready = 1'b1;
      #1;
      check("full_no_ready_through", 64'(in_ready), 64'd0);
      step();
      ifmap_ready = 1'b0;
      #1;
      check("after_pop_in_ready", 64'(in_ready), 64'd1);
      ifmap_q.push_back(rows[4]);
      step();
      in_valid = 1'b0;
      ifmap_ready = 1'b1;
    end
    drain("fifo_order_drain");
    check("fifo_empty_after", 64'(ifmap_valid), 64'd0);

    // Tx back-pressure: packet held stable while out_ready is low
    out_ready = 1'b0;
    step();
    spike_valid = 1'b1; spike_x = 5'd3; spike_y = 5'd17; spike_done = 1'b0;
    #1;
    check("tx_idle_spike_ready", 64'(spike_ready), 64'd1);
    out_q.push_back(tx_pkt(5'd3, 5'd17, 1'b0));
    step();
    spike_x = 5'd7; spike_y = 5'd2;
    #1;
    for (int c = 0; c < 3; c++) begin
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_out_data", out_data, tx_pkt(5'd3, 5'd17, 1'b0));
      check("stall_spike_ready", 64'(spike_ready), 64'd0);
      if (c < 2) step();
    end
    out_ready = 1'b1;
    #1;
    check("release_spike_ready", 64'(spike_ready), 64'd1);
    out_q.push_back(tx_pkt(5'd7, 5'd2, 1'b0));
    step();
    spike_valid = 1'b0;
    #1;
    check("b2b_second_pkt", out_data, tx_pkt(5'd7, 5'd2, 1'b0));
    step();
    check("tx_back_idle", 64'(out_valid), 64'd0);

    // Back-to-back spikes, one done marker, and an Rx kernel in parallel
    begin
      logic [4:0] xs [4];
      logic [4:0] ys [4];
      logic       ds [4];
      xs[0] = 5'd1;  ys[0] = 5'd2;  ds[0] = 1'b0;
      xs[1] = 5'd15; ys[1] = 5'd31; ds[1] = 1'b0;
      xs[2] = 5'd5;  ys[2] = 5'd6;  ds[2] = 1'b1;
      xs[3] = 5'd30; ys[3] = 5'd0;  ds[3] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        step();
        spike_valid = 1'b1; spike_x = xs[i]; spike_y = ys[i]; spike_done = ds[i];
        in_valid = (i == 0);
        in_data  = rx_pkt(TB_PE, 2'b01, {14'h0, 40'h0102030405});
        #1;
        check("b2b_spike_ready", 64'(spike_ready), 64'd1);
        out_q.push_back(tx_pkt(xs[i], ys[i], ds[i]));
      end
      step();
      spike_valid = 1'b0; spike_done = 1'b0; in_valid = 1'b0;
    end
    drain("b2b_drain");
    step();
    check("b2b_idle", 64'(out_valid), 64'd0);
    check("ts_after_one_done", 64'(timestep), 64'd1);
    check("parallel_kernel_row", 64'(filter_row), 64'h0102030405);

    // Reset mid-operation with two buffered rows and a pending packet
    ifmap_ready = 1'b0; out_ready = 1'b0;
    step();
    in_valid = 1'b1; in_data = rx_pkt(TB_PE, 2'b00, 54'h0000123);
    spike_valid = 1'b1; spike_x = 5'd9; spike_y = 5'd9;
    step();
    in_data = rx_pkt(TB_PE, 2'b00, 54'h0000456);
    spike_valid = 1'b0;
    step();
    in_valid = 1'b0;
    #1;
    check("pre_rst_ifmap_valid", 64'(ifmap_valid), 64'd1);
    check("pre_rst_out_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    step();
    reset = 1'b0;
    #1;
    check("post_rst_ifmap_valid", 64'(ifmap_valid), 64'd0);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);
    check("post_rst_out_data", out_data, 64'd0);
    check("post_rst_timestep", 64'(timestep), 64'd0);
    check("post_rst_filter_valid", 64'(filter_valid), 64'd0);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    step();
    check("post_rst_still_empty", 64'({ifmap_valid, out_valid}), 64'd0);

    // Ten done markers: timestep counts up and wraps to zero
    out_ready = 1'b1; ifmap_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      spike_valid = 1'b1; spike_done = 1'b1; spike_x = 5'(i); spike_y = 5'd31;
      out_q.push_back(tx_pkt(5'(i), 5'd31, 1'b1));
      step();
      spike_valid = 1'b0; spike_done = 1'b0;
      step();
      step();
      check("ts_count", 64'(timestep), 64'(i % 10));
    end

    drain("final_drain");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
